// File: rtl/keypad_emulator.sv
// Passive 4x4 matrix keypad model: presses one key per request, with contact bounce on
// press and release, and answers column strobes combinationally on the row lines.
module keypad_emulator #(
   parameter int unsigned HOLD_CYCLES   = 1_000_000,
   parameter int unsigned BOUNCE_CYCLES = 50_000,
   parameter int unsigned BOUNCE_PERIOD = 5_000,
   parameter int unsigned GAP_CYCLES    = 500_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col,
   output logic [3:0] row,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   output logic       busy,
   output logic       done,
   output logic       contact
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      B_PRESS = 3'd1,
      HOLD    = 3'd2,
      B_REL   = 3'd3,
      GAP     = 3'd4
   } state_t;

   localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES) - 32'd1;
   localparam logic [31:0] BOUNCE_LAST = 32'(BOUNCE_CYCLES) - 32'd1;
   localparam logic [31:0] PERIOD_LAST = 32'(BOUNCE_PERIOD) - 32'd1;
   localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES != 0);
   localparam bit          HAS_GAP     = (GAP_CYCLES != 0);
   localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES) - 32'd1;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] per_q, per_d;
   logic        contact_q, contact_d;
   logic [3:0]  code_q, code_d;
   logic        key_ready_q, key_ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        accept;

   assign accept = key_valid & key_ready_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 32'd1;
      per_d     = per_q;
      contact_d = contact_q;
      code_d    = code_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               code_d    = key_code;
               contact_d = 1'b1;
               per_d     = '0;
               state_d   = HAS_BOUNCE ? B_PRESS : HOLD;
            end
         end
         B_PRESS, B_REL: begin
            if (cnt_q == BOUNCE_LAST) begin
               cnt_d = '0;
               per_d = '0;
               if (state_q == B_PRESS) begin
                  state_d   = HOLD;
                  contact_d = 1'b1;
               end else begin
                  state_d   = HAS_GAP ? GAP : IDLE;
                  contact_d = 1'b0;
                  done_d    = !HAS_GAP;
               end
            end else if (per_q == PERIOD_LAST) begin
               per_d     = '0;
               contact_d = ~contact_q;
            end else begin
               per_d = per_q + 32'd1;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d     = '0;
               per_d     = '0;
               contact_d = 1'b0;
               if (HAS_BOUNCE) begin
                  state_d = B_REL;
               end else begin
                  state_d = HAS_GAP ? GAP : IDLE;
                  done_d  = !HAS_GAP;
               end
            end
         end
         GAP: begin
            contact_d = 1'b0;
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            contact_d = 1'b0;
         end
      endcase
      key_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         per_q       <= '0;
         contact_q   <= 1'b0;
         code_q      <= '0;
         key_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         per_q       <= per_d;
         contact_q   <= contact_d;
         code_q      <= code_d;
         key_ready_q <= key_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Switch path: no register between col and row, like a real contact.
   always_comb begin
      row = 4'b1111;
      if (contact_q && !col[code_q[1:0]])
         row = ~(4'b0001 << code_q[3:2]);
   end

   assign key_ready = key_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign contact   = contact_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: bounce timing, row response, busy-ignore,
// no-bounce variant, async reset and a scan-decode loopback over all 16 keys.
module tb_keypad_emulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] col, row;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready, busy, done, contact;

   logic [3:0] nb_col, nb_row;
   logic       nb_valid;
   logic [3:0] nb_code;
   logic       nb_ready, nb_busy, nb_done, nb_contact;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   keypad_emulator #(.HOLD_CYCLES(20), .BOUNCE_CYCLES(6), .BOUNCE_PERIOD(2), .GAP_CYCLES(10))
   u_dut (
      .clk(clk), .rst_n(rst_n), .col(col), .row(row),
      .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
      .busy(busy), .done(done), .contact(contact)
   );

   keypad_emulator #(.HOLD_CYCLES(20), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(2), .GAP_CYCLES(10))
   u_nb (
      .clk(clk), .rst_n(rst_n), .col(nb_col), .row(nb_row),
      .key_valid(nb_valid), .key_code(nb_code), .key_ready(nb_ready),
      .busy(nb_busy), .done(nb_done), .contact(nb_contact)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Contact level in cycle T+k for the bounced press (BOUNCE=6, PERIOD=2, HOLD=20, GAP=10).
   function automatic logic exp_contact(input int k);
      if (k <= 6)  return (((k - 1) / 2) % 2) == 0;
      if (k <= 26) return 1'b1;
      if (k <= 32) return (((k - 27) / 2) % 2) == 1;
      return 1'b0;
   endfunction

   initial begin
      rst_n = 1'b0; col = 4'b1111; key_valid = 1'b0; key_code = 4'h0;
      nb_col = 4'b1111; nb_valid = 1'b0; nb_code = 4'h0;
      #22;
      chk("rst_row", row, 4'b1111);
      chk("rst_ready", key_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_contact", contact, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Bounced press of 4'h6 with a busy-time request for 4'hF that must be ignored
      key_code = 4'h6; key_valid = 1'b1; col = 4'b1011;
      step();
      key_valid = 1'b0;
      for (int k = 1; k <= 44; k++) begin
         if (k == 5)  begin key_valid = 1'b1; key_code = 4'hF; end
         if (k == 41) key_valid = 1'b0;
         chk($sformatf("contact_k%0d", k), contact, exp_contact(k));
         chk($sformatf("row_k%0d", k), row, exp_contact(k) ? 4'b1101 : 4'b1111);
         chk($sformatf("done_k%0d", k), done, k == 43);
         chk($sformatf("ready_k%0d", k), key_ready, k >= 43);
         chk($sformatf("busy_k%0d", k), busy, k <= 42);
         if (k == 10) begin
            col = 4'b1110; #1; chk("hold_col1110", row, 4'b1111);
            col = 4'b0000; #1; chk("hold_col0000", row, 4'b1101);
            col = 4'b1011; #1; chk("hold_col1011", row, 4'b1101);
         end
         step();
      end
      col = 4'b1111;

      // No-bounce variant: key 4'h9 (r=2, c=1)
      nb_code = 4'h9; nb_valid = 1'b1; nb_col = 4'b1101;
      step();
      nb_valid = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         chk($sformatf("nb_contact_k%0d", k), nb_contact, k <= 20);
         chk($sformatf("nb_row_k%0d", k), nb_row, (k <= 20) ? 4'b1011 : 4'b1111);
         chk($sformatf("nb_done_k%0d", k), nb_done, k == 31);
         step();
      end
      nb_col = 4'b1111;

      // Async reset in HOLD releases row without a clock edge
      key_code = 4'h3; key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      repeat (10) step();
      col = 4'b0111; #1;
      chk("prerst_row", row, 4'b1110);
      #1 rst_n = 1'b0;
      #1;
      chk("async_row", row, 4'b1111);
      chk("async_contact", contact, 0);
      @(negedge clk);
      rst_n = 1'b1;
      col = 4'b1111;
      step();
      chk("postrst_ready", key_ready, 1);
      chk("postrst_busy", busy, 0);

      // Loopback: scan the no-bounce keypad for every code and decode it
      for (int code = 0; code < 16; code++) begin
         int hits;
         int dec;
         bit seen;
         nb_code = 4'(code); nb_valid = 1'b1;
         step();
         nb_valid = 1'b0;
         repeat (3) step();
         hits = 0; dec = 0;
         for (int c = 0; c < 4; c++) begin
            nb_col = ~(4'b0001 << c);
            #1;
            for (int r = 0; r < 4; r++)
               if (!nb_row[r]) begin hits++; dec = r * 4 + c; end
         end
         nb_col = 4'b1111;
         chk($sformatf("scan_hits_%0h", code), hits, 1);
         chk($sformatf("scan_code_%0h", code), dec, code);
         seen = 1'b0;
         for (int t = 0; t < 60 && !seen; t++) begin
            step();
            seen = nb_done;
         end
         chk($sformatf("scan_done_%0h", code), seen, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
